// File: rtl/csa_seq_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : csa_seq_sched_if
//  Description : Bundle of request, shared-adder and result signals for
//                csa_seq_sched.
//                  req_*  : two requesters (valid/ready, operands, carry-in)
//                  dp_*   : drive to / results from the shared chunk adder
//                  res_*  : result channel (valid/ready, sum, carry-out, id)
//                The slave modport is the scheduler's view; the master
//                modport is the view of the surrounding environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface csa_seq_sched_if #(
    parameter int WIDTH  = 8,
    parameter int NCHUNK = 4
);
    localparam int W = WIDTH * NCHUNK;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [W-1:0]     req_a0;
    logic [W-1:0]     req_b0;
    logic [W-1:0]     req_a1;
    logic [W-1:0]     req_b1;
    logic [1:0]       req_cin;

    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_p;
    logic             dp_cin;
    logic [WIDTH-1:0] dp_s;
    logic             dp_cout;

    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_sum;
    logic             res_cout;
    logic             res_id;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_cin,
        input  dp_s, dp_cout, res_ready,
        output req_ready, dp_a, dp_b, dp_p, dp_cin,
        output res_valid, res_sum, res_cout, res_id
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_cin,
        output dp_s, dp_cout, res_ready,
        input  req_ready, dp_a, dp_b, dp_p, dp_cin,
        input  res_valid, res_sum, res_cout, res_id
    );
endinterface
`default_nettype wire

// File: rtl/csa_seq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : csa_seq_sched
//  Description : Two-requester scheduler for a shared WIDTH-bit carry-select
//                adder. An accepted request of WIDTH*NCHUNK-bit operands is
//                added one chunk per cycle (LSB chunk first), rippling the
//                carry through a register, and the result is presented on
//                a valid/ready result channel.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - csa_seq_sched_if.slave (requests, adder, result)
//                busy - high whenever the scheduler is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_seq_sched #(
    parameter int WIDTH  = 8,
    parameter int NCHUNK = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    csa_seq_sched_if.slave     bus,
    output logic               busy
);
    localparam int                c_W      = WIDTH * NCHUNK;
    localparam int                c_KW     = $clog2(NCHUNK);
    localparam logic [c_KW-1:0]   c_K_LAST = c_KW'(NCHUNK - 1);
    localparam logic [c_KW-1:0]   c_K_ONE  = c_KW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [c_KW-1:0]   r_k_q,     w_k_d;
    logic              r_carry_q, w_carry_d;
    logic              r_last_q,  w_last_d;   // requester granted last
    logic              r_id_q,    w_id_d;
    logic [c_W-1:0]    r_a_q,     w_a_d;
    logic [c_W-1:0]    r_b_q,     w_b_d;
    logic [c_W-1:0]    r_sum_q,   w_sum_d;

    logic              w_grant;
    logic [1:0]        w_req_ready;
    logic [WIDTH-1:0]  w_dp_a;
    logic [WIDTH-1:0]  w_dp_b;
    logic              w_dp_cin;
    int                w_off;

    always_comb begin
        w_state_d   = r_state_q;
        w_k_d       = r_k_q;
        w_carry_d   = r_carry_q;
        w_last_d    = r_last_q;
        w_id_d      = r_id_q;
        w_a_d       = r_a_q;
        w_b_d       = r_b_q;
        w_sum_d     = r_sum_q;
        w_req_ready = 2'b00;
        w_dp_a      = '0;
        w_dp_b      = '0;
        w_dp_cin    = 1'b0;
        w_off       = int'(r_k_q) * WIDTH;

        // Sole valid requester wins; on contention the one not served last.
        w_grant = (bus.req_valid == 2'b11) ? ~r_last_q : bus.req_valid[1];

        case (r_state_q)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    w_req_ready[w_grant] = 1'b1;
                    w_a_d     = w_grant ? bus.req_a1 : bus.req_a0;
                    w_b_d     = w_grant ? bus.req_b1 : bus.req_b0;
                    w_carry_d = bus.req_cin[w_grant];
                    w_id_d    = w_grant;
                    w_last_d  = w_grant;
                    w_k_d     = '0;
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_dp_a    = r_a_q[w_off +: WIDTH];
                w_dp_b    = r_b_q[w_off +: WIDTH];
                w_dp_cin  = r_carry_q;
                w_sum_d[w_off +: WIDTH] = bus.dp_s;
                // After the last chunk the carry register holds the final
                // carry-out, which is what res_cout shows in DONE.
                w_carry_d = bus.dp_cout;
                if (r_k_q == c_K_LAST) begin
                    w_state_d = S_DONE;
                end else begin
                    w_k_d = r_k_q + c_K_ONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_k_q     <= '0;
            r_carry_q <= 1'b0;
            r_last_q  <= 1'b1;      // so requester 0 wins the first contention
            r_id_q    <= 1'b0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sum_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_k_q     <= w_k_d;
            r_carry_q <= w_carry_d;
            r_last_q  <= w_last_d;
            r_id_q    <= w_id_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_sum_q   <= w_sum_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign bus.req_ready = rst ? 2'b00 : w_req_ready;
    assign bus.res_valid = ~rst & (r_state_q == S_DONE);
    assign busy          = ~rst & (r_state_q != S_IDLE);

    assign bus.dp_a      = w_dp_a;
    assign bus.dp_b      = w_dp_b;
    assign bus.dp_p      = w_dp_a ^ w_dp_b;
    assign bus.dp_cin    = w_dp_cin;

    assign bus.res_sum   = r_sum_q;
    assign bus.res_cout  = r_carry_q;
    assign bus.res_id    = r_id_q;
endmodule
`default_nettype wire
